// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared widths and write-request type for the register-file write arbiter
package rf_arb_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } rf_wr_req_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits for long-latency destinations
// Set on issue, cleared on port-B writeback; a same-cycle set beats the clear.
module rf_scoreboard
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W = rf_arb_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_valid,
  input  logic [ADDR_W-1:0]    set_rd,
  input  logic                 clr_valid,
  input  logic [ADDR_W-1:0]    clr_rd,
  output logic [2**ADDR_W-1:0] busy
);
  logic [2**ADDR_W-1:0] set_mask;
  logic [2**ADDR_W-1:0] clr_mask;
  logic [2**ADDR_W-1:0] busy_next;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid) set_mask[set_rd] = 1'b1;
    if (clr_valid) clr_mask[clr_rd] = 1'b1;
    busy_next    = (busy & ~clr_mask) | set_mask;
    // x0 is hardwired zero, so it can never be pending
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  always @(posedge clk) begin
    if (!reset && set_valid && (set_rd != '0)) begin
      assert (!busy[set_rd]);
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-source register-file write port arbiter with pending scoreboard
// Optional port-B anti-starvation override: RF_ARB_STARVE_EN.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W     = rf_arb_pkg::DATA_W,
  parameter int ADDR_W     = rf_arb_pkg::ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  input  logic [ADDR_W-1:0]    a_rd,
  input  logic [DATA_W-1:0]    a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_W-1:0]    b_rd,
  input  logic [DATA_W-1:0]    b_data,
  output logic                 b_ready,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic                 rf_regWrite,
  output logic [ADDR_W-1:0]    rf_rd,
  output logic [DATA_W-1:0]    rf_writeData,
  output logic [2**ADDR_W-1:0] busy
);
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  rf_wr_req_t a_req;
  rf_wr_req_t b_req;
  rf_wr_req_t out_q;
  logic       force_b;

  assign a_req = '{rd: a_rd, data: a_data};
  assign b_req = '{rd: b_rd, data: b_data};

`ifdef RF_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_b = a_valid && b_valid && (starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset || !b_valid || b_ready)            starve_cnt <= '0;
    else if (starve_cnt != CNT_W'(STARVE_MAX))   starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign force_b = 1'b0;
`endif

  assign a_ready = !reset && a_valid && !force_b;
  assign b_ready = !reset && b_valid && (!a_valid || force_b);

  // An x0 write is consumed but leaves the output register untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_regWrite <= 1'b0;
      out_q       <= '0;
    end else begin
      rf_regWrite <= 1'b0;
      if (a_ready && (a_rd != '0)) begin
        rf_regWrite <= 1'b1;
        out_q       <= a_req;
      end else if (b_ready && (b_rd != '0)) begin
        rf_regWrite <= 1'b1;
        out_q       <= b_req;
      end
    end
  end

  assign rf_rd        = out_q.rd;
  assign rf_writeData = out_q.data;

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (issue_valid),
    .set_rd    (issue_rd),
    .clr_valid (b_ready),
    .clr_rd    (b_rd),
    .busy      (busy)
  );
endmodule
